prot_cpu_if: RTL and testbench
==============================

PROT_CPU_IF -- requirements
Module: prot_cpu_if

Interface
REQ-001 Parameter DEPTH, default 4: write-queue entries; power of two, 2..16.
REQ-002 Parameter WR_HIGH, default 2: clk_sys cycles prot_wr is held high per write, >=1.
REQ-003 Parameter WR_GAP, default 2: clk_sys cycles prot_wr is held low between writes, >=1.
REQ-004 clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset; synchronous to clk_sys, active-low.
REQ-006 cpu_ce  in  1  CPU bus-cycle enable; one clk_sys pulse per CPU cycle.
REQ-007 cpu_cs  in  1  chip select for the protection register window.
REQ-008 cpu_a0  in  1  register select; 0 = data, 1 = status/control.
REQ-009 cpu_rw  in  1  1 = read, 0 = write.
REQ-010 cpu_dout  in  8  CPU write data.
REQ-011 cpu_din  out  8  registered read data to the CPU.
REQ-012 prot_wr  out  1  write strobe to the protection core; core acts on its rising edge.
REQ-013 prot_wdata  out  8  data to the protection core; stable for the whole prot_wr high phase.
REQ-014 prot_dout  in  8  protection core result byte.
REQ-015 prot_status  in  8  protection core status byte.
REQ-016 fifo_ovf  out  1  sticky overflow flag.

Function
REQ-017 Bus access SHALL be sampled only in cycles where cpu_ce=1 and cpu_cs=1; all other cycles ignore the CPU inputs.
REQ-018 Write, a0=0: SHALL push cpu_dout into the write queue.
REQ-019 Write, a0=1: SHALL clear fifo_ovf; data ignored; nothing queued.
REQ-020 Read, a0=0: cpu_din SHALL load prot_dout on the next clk_sys edge.
REQ-021 Read, a0=1: cpu_din SHALL load {prot_status[7:1], busy} on the next clk_sys edge.
- busy = queue non-empty OR FSM not in IDLE.
REQ-022 cpu_din SHALL hold its value in all cycles without a sampled read.
REQ-023 The write queue SHALL be FIFO ordered, DEPTH entries, with a count of width log2(DEPTH)+1 and read/write pointers wrapping modulo DEPTH.
REQ-024 Push while full with no pop in the same cycle: data SHALL be dropped and fifo_ovf set to 1.
REQ-025 Push while full with a pop in the same cycle: push SHALL be accepted and count unchanged.
REQ-026 fifo_ovf SHALL stay 1 until cleared by a write to a0=1 or by reset.
- If set and clear occur in the same cycle, set wins.
REQ-027 The pacing FSM SHALL have three states: IDLE, HIGH, GAP.
REQ-028 IDLE: if the queue is non-empty, SHALL pop the head into prot_wdata, load the counter with WR_HIGH-1, and go to HIGH; otherwise stay in IDLE.
REQ-029 HIGH: prot_wr=1; SHALL decrement the counter; at 0, load WR_GAP-1 and go to GAP.
REQ-030 GAP: prot_wr=0; SHALL decrement the counter; at 0, go to IDLE.
REQ-031 prot_wr SHALL be registered and high exactly in HIGH-state cycles; each dequeued byte SHALL produce exactly one rising edge.
REQ-032 Latency: a push sampled at edge N into an empty, idle block SHALL give prot_wr=1 and valid prot_wdata from edge N+2.
REQ-033 prot_wdata SHALL hold its last value after the pulse ends.
REQ-034 Byte-to-byte spacing SHALL be WR_HIGH+WR_GAP+1 cycles between rising edges of prot_wr.

Reset
REQ-035 While reset_n=0 at a clk_sys edge, the following SHALL hold:
- FSM to IDLE, counter 0;
- queue emptied, pointers 0;
- prot_wr=0, prot_wdata=0x00, cpu_din=0x00, fifo_ovf=0.
REQ-036 Reset asserted mid-pulse SHALL drop prot_wr on the same edge and discard all queued bytes.
REQ-037 Bus accesses sampled during reset SHALL be ignored.

Verification
REQ-038 Single write: write 0x80 to a0=0 at edge N -> prot_wr high at edges N+2..N+3, prot_wdata=0x80, one rising edge.
REQ-039 Burst: write 0x80,0x80,0x10,0x80 on consecutive cpu_ce -> same order at prot_wdata, rising edges 5 cycles apart, no ovf.
REQ-040 Overflow: DEPTH=4, six writes back-to-back with prot pacing stalled in HIGH -> 5th and/or 6th dropped, fifo_ovf=1; write a0=1 -> fifo_ovf=0.
REQ-041 Status read: prot_status=0x02 with queue busy -> cpu_din=0x03; after drain -> cpu_din=0x02; read a0=0 with prot_dout=0x05 -> cpu_din=0x05.
REQ-042 Reset mid-pulse: reset_n=0 during HIGH with 2 bytes queued -> prot_wr=0 next edge, queue empty, no further pulses after release.
REQ-043 Full push/pop coincidence: queue full, push in the IDLE pop cycle -> accepted, fifo_ovf stays 0, all bytes delivered in order.

Source files
------------

// File: rtl/prot_cpu_if.sv
// CPU-side bridge to the protection core: queues CPU data writes and replays
// them as paced prot_wr pulses, and returns core result/status bytes on reads.
module prot_cpu_if #(
    parameter int DEPTH   = 4,
    parameter int WR_HIGH = 2,
    parameter int WR_GAP  = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cpu_ce,
    input  logic       cpu_cs,
    input  logic       cpu_a0,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    output logic       prot_wr,
    output logic [7:0] prot_wdata,
    input  logic [7:0] prot_dout,
    input  logic [7:0] prot_status,
    output logic       fifo_ovf
);

    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_MAX = (WR_HIGH > WR_GAP) ? WR_HIGH : WR_GAP;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [7:0]    wdata_r;
    logic [7:0]    din_r;
    logic          wr_r;
    logic          ovf_r;

    logic access_s;
    logic push_s;
    logic clr_s;
    logic read_s;
    logic pop_s;
    logic full_s;
    logic push_ok_s;
    logic ovf_set_s;
    logic busy_s;
    logic unused_s;

    // Decode sampled bus cycles and queue handshakes
    always_comb begin
        access_s  = 1'b0;
        push_s    = 1'b0;
        clr_s     = 1'b0;
        read_s    = 1'b0;
        pop_s     = 1'b0;
        full_s    = 1'b0;
        push_ok_s = 1'b0;
        ovf_set_s = 1'b0;
        busy_s    = 1'b0;
        access_s  = cpu_ce & cpu_cs & reset_n;
        push_s    = access_s & ~cpu_rw & ~cpu_a0;
        clr_s     = access_s & ~cpu_rw & cpu_a0;
        read_s    = access_s & cpu_rw;
        pop_s     = (state_r == ST_IDLE) && (count_r != {(AW+1){1'b0}});
        full_s    = (count_r == (AW+1)'(DEPTH));
        // A full queue still accepts a push when the head leaves in the same cycle
        push_ok_s = push_s & (~full_s | pop_s);
        ovf_set_s = push_s & full_s & ~pop_s;
        busy_s    = (count_r != {(AW+1){1'b0}}) || (state_r != ST_IDLE);
    end

    assign unused_s = prot_status[0];

    // Queue storage, written only on accepted pushes
    always_ff @(posedge clk_sys) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= cpu_dout;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_s);
        end
    end

    // Pacing FSM: one prot_wr pulse of WR_HIGH cycles, then WR_GAP low cycles
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            wr_r    <= 1'b0;
            wdata_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        wdata_r <= mem_r[rd_ptr_r];
                        cnt_r   <= CW'(WR_HIGH - 1);
                        wr_r    <= 1'b1;
                        state_r <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        cnt_r   <= CW'(WR_GAP - 1);
                        wr_r    <= 1'b0;
                        state_r <= ST_GAP;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                    wr_r    <= 1'b0;
                end
            endcase
        end
    end

    // CPU read data and sticky overflow; a set beats a clear in the same cycle
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            din_r <= 8'h00;
            ovf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (clr_s) begin
                ovf_r <= 1'b0;
            end
            if (read_s) begin
                din_r <= cpu_a0 ? {prot_status[7:1], busy_s} : prot_dout;
            end
        end
    end

    assign cpu_din    = din_r;
    assign prot_wr    = wr_r;
    assign prot_wdata = wdata_r;
    assign fifo_ovf   = ovf_r;

endmodule

// File: tb/tb_prot_cpu_if.sv
// Bench for prot_cpu_if: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of queue, pacing and bus reads.
module tb_prot_cpu_if;

    localparam int DEPTH   = 4;
    localparam int WR_HIGH = 2;
    localparam int WR_GAP  = 2;
    localparam int SPACING = WR_HIGH + WR_GAP + 1;

    logic       clk_sys     = 1'b0;
    logic       reset_n     = 1'b0;
    logic       cpu_ce      = 1'b0;
    logic       cpu_cs      = 1'b0;
    logic       cpu_a0      = 1'b0;
    logic       cpu_rw      = 1'b1;
    logic [7:0] cpu_dout    = 8'h00;
    logic [7:0] prot_dout   = 8'h00;
    logic [7:0] prot_status = 8'h00;
    logic [7:0] cpu_din;
    logic       prot_wr;
    logic [7:0] prot_wdata;
    logic       fifo_ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] q[$];
    int         edge_n   = 0;
    int         next_pop = 0;
    int         last_r   = -100;
    logic [7:0] m_wdata  = 8'h00;
    logic [7:0] m_din    = 8'h00;
    logic       m_ovf    = 1'b0;

    prot_cpu_if #(.DEPTH(DEPTH), .WR_HIGH(WR_HIGH), .WR_GAP(WR_GAP)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .cpu_ce      (cpu_ce),
        .cpu_cs      (cpu_cs),
        .cpu_a0      (cpu_a0),
        .cpu_rw      (cpu_rw),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .prot_wr     (prot_wr),
        .prot_wdata  (prot_wdata),
        .prot_dout   (prot_dout),
        .prot_status (prot_status),
        .fifo_ovf    (fifo_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        bit access, pop, full, busy;
        edge_n++;
        if (!reset_n) begin
            q.delete();
            next_pop = 0;
            last_r   = -100;
            m_wdata  = 8'h00;
            m_din    = 8'h00;
            m_ovf    = 1'b0;
        end else begin
            access = cpu_ce && cpu_cs;
            busy   = (q.size() > 0) || (edge_n < next_pop);
            pop    = (q.size() > 0) && (edge_n >= next_pop);
            full   = (q.size() == DEPTH);
            if (pop) begin
                m_wdata  = q.pop_front();
                last_r   = edge_n;
                next_pop = edge_n + SPACING;
            end
            if (access && !cpu_rw && !cpu_a0) begin
                if (!full || pop) q.push_back(cpu_dout);
                else m_ovf = 1'b1;
            end
            if (access && !cpu_rw && cpu_a0) m_ovf = 1'b0;
            if (access && cpu_rw) m_din = cpu_a0 ? {prot_status[7:1], busy} : prot_dout;
        end
    endtask

    task automatic step(input logic ce, input logic cs, input logic a0, input logic rw,
                        input logic [7:0] d);
        logic exp_wr;
        cpu_ce   = ce;
        cpu_cs   = cs;
        cpu_a0   = a0;
        cpu_rw   = rw;
        cpu_dout = d;
        @(posedge clk_sys);
        model_step();
        #1;
        exp_wr = (edge_n >= last_r) && (edge_n <= last_r + WR_HIGH - 1);
        check("prot_wr",    {7'd0, prot_wr},  {7'd0, exp_wr});
        check("prot_wdata", prot_wdata,       m_wdata);
        check("cpu_din",    cpu_din,          m_din);
        check("fifo_ovf",   {7'd0, fifo_ovf}, {7'd0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        step(1'b1, 1'b1, a0, 1'b0, d);
    endtask

    task automatic rd(input logic a0);
        step(1'b1, 1'b1, a0, 1'b1, 8'h00);
    endtask

    initial begin
        // Reset, with a write attempted while reset is held
        reset_n = 1'b0;
        idle(2);
        wr(1'b0, 8'h5A);
        check("reset_wr",  {7'd0, prot_wr},  8'h00);
        check("reset_ovf", {7'd0, fifo_ovf}, 8'h00);
        check("reset_din", cpu_din,          8'h00);
        reset_n = 1'b1;
        idle(8);

        // Single write, then burst of four
        wr(1'b0, 8'h80);
        idle(10);
        wr(1'b0, 8'h80);
        wr(1'b0, 8'h80);
        wr(1'b0, 8'h10);
        wr(1'b0, 8'h80);
        idle(24);

        // Status and data reads
        prot_status = 8'h02;
        wr(1'b0, 8'h11);
        rd(1'b1);
        check("status_busy", cpu_din, 8'h03);
        idle(10);
        rd(1'b1);
        check("status_idle", cpu_din, 8'h02);
        prot_dout = 8'h05;
        rd(1'b0);
        check("data_read", cpu_din, 8'h05);
        idle(3);
        check("din_hold", cpu_din, 8'h05);

        // Overflow with six back-to-back writes, then clear
        for (int i = 0; i < 6; i++) wr(1'b0, 8'(8'hA0 + i));
        check("ovf_set", {7'd0, fifo_ovf}, 8'h01);
        wr(1'b1, 8'hFF);
        check("ovf_clear", {7'd0, fifo_ovf}, 8'h00);
        idle(30);

        // Full queue, push lands on the pop cycle
        for (int i = 0; i < 5; i++) wr(1'b0, 8'(8'hC0 + i));
        idle(1);
        wr(1'b0, 8'hC5);
        check("coincide_ovf", {7'd0, fifo_ovf}, 8'h00);
        idle(35);

        // Reset during a pulse with two bytes still queued
        wr(1'b0, 8'hE1);
        wr(1'b0, 8'hE2);
        wr(1'b0, 8'hE3);
        check("pulse_before_reset", {7'd0, prot_wr}, 8'h01);
        reset_n = 1'b0;
        idle(1);
        check("pulse_dropped", {7'd0, prot_wr}, 8'h00);
        reset_n = 1'b1;
        idle(15);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            prot_dout   = 8'($urandom);
            prot_status = 8'($urandom);
            reset_n     = ($urandom_range(0, 99) != 0);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
        end
        reset_n = 1'b1;
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
